fq_measure_scheduler: RTL and testbench
=======================================

// Module: fq_measure_scheduler
// PURPOSE
//  Sequences one shared frequency-count engine across N_CH input channels, all in the reference-clock domain.
//  Round-robin scan: select channel, wait for mux settle, open a GATE_CYCLES gate window, then wait for the count.
//  Stores the last count per channel, plus valid/timeout flags, for readback.
// PARAMETERS
//  N_CH           4        number of measured channels (2..16)
//  GATE_CYCLES    1000000  gate length in Clock cycles (1 s at 1 MHz ref)
//  SETTLE_CYCLES  4        idle cycles after a mux change, before meas_start
//  TIMEOUT_CYCLES 1000     max cycles in WAIT_DONE before the timeout is flagged
// PORTS
//  Clock       in   1               reference clock; all logic is on posedge
//  nReset      in   1               asynchronous, active-low reset
//  scan_en     in   1               enable continuous scanning
//  ch_enable   in   N_CH            per-channel include mask
//  meas_sel    out  $clog2(N_CH)    channel mux select to engine
//  meas_start  out  1               1-cycle pulse: engine clears its count
//  meas_gate   out  1               high during the gate window
//  meas_done   in   1               1-cycle pulse: meas_count is valid
//  meas_count  in   32              engine count for the last gate
//  rd_sel      in   $clog2(N_CH)    readback channel index
//  rd_data     out  32              result[rd_sel]; 0 if rd_sel >= N_CH (combinational)
//  rd_valid    out  N_CH            per-channel: result holds a completed count
//  rd_timeout  out  N_CH            per-channel: last attempt timed out
//  busy        out  1               high in any state other than IDLE
//  scan_done   out  1               1-cycle pulse when a rotation completes
// BEHAVIOUR
//  Reset: all outputs, results and flags = 0; state IDLE; rotation pointer = N_CH-1, so ch0 is served first.
//  Next channel: first enabled index after the pointer, modulo N_CH, searched over the ch_enable mask.
//  IDLE: scan_en & |ch_enable -> SELECT; otherwise stay in IDLE.
//  SELECT (1 cycle): meas_sel <= next channel; pointer <= that channel -> SETTLE.
//  SETTLE: count SETTLE_CYCLES cycles; on the last, meas_start=1 for 1 cycle -> GATE.
//  GATE: meas_gate=1 for exactly GATE_CYCLES cycles, starting the cycle after meas_start -> WAIT_DONE.
//  WAIT_DONE: on meas_done, result[sel] <= meas_count; rd_valid[sel] <= 1; rd_timeout[sel] <= 0 -> NEXT.
//   - After TIMEOUT_CYCLES cycles without meas_done: rd_timeout[sel] <= 1; result and rd_valid unchanged -> NEXT.
//   - meas_done and the timeout in the same cycle: meas_done wins.
//  NEXT (1 cycle): scan_done=1 if sel is the highest enabled index in the current ch_enable.
//   - Then -> SELECT if scan_en & |ch_enable, else -> IDLE.
//  meas_done outside WAIT_DONE: ignored; no state or flag change.
//  scan_en dropped mid-measurement: the current channel completes through NEXT, then -> IDLE.
//  ch_enable changes mid-measurement: the current channel still completes and is stored.
//   - The new mask applies from the next SELECT.
//  ch_enable all zero while scanning: finish the current channel, then -> IDLE.
//  Cycle counters are 32-bit. They reset to 0 on each state entry and never wrap within their bound.
//  Per-channel latency, SELECT to NEXT: 1 + SETTLE_CYCLES + GATE_CYCLES + done delay (<= TIMEOUT_CYCLES) + 1.
//  meas_sel holds stable from SELECT through NEXT; it never changes while meas_gate=1.
//  Async reset mid-gate: meas_gate and meas_start drop immediately; stored results are cleared.
// TESTING  (bench: GATE_CYCLES=100, SETTLE_CYCLES=4, TIMEOUT_CYCLES=50, N_CH=4)
//  1. ch_enable=4'b0101, scan_en=1, engine returns 1234/5678 for ch0/ch2, done 3 cycles after gate.
//     -> meas_sel sequence 0,2,0...; meas_gate high exactly 100 cycles.
//     -> result0=1234, result2=5678; rd_valid=4'b0101; scan_done pulses once per ch2 completion.
//  2. Enable ch1 only; engine never asserts meas_done.
//     -> rd_timeout[1]=1 exactly 50 cycles after gate end; rd_valid[1]=0; scan continues on ch1.
//  3. meas_done pulsed during SETTLE and GATE.
//     -> ignored; the state sequence and gate length are unchanged.
//  4. scan_en dropped in mid-gate of ch3.
//     -> ch3 gate completes to 100 cycles; result3 stored; busy=0 the cycle after NEXT; no new meas_start.
//  5. ch_enable changed from 4'b1111 to 4'b0010 while measuring ch2.
//     -> ch2 is stored; next meas_sel=1; ch3 is never selected.
//  6. nReset asserted mid-gate.
//     -> meas_gate=0, busy=0 and rd_valid=0 immediately.
//     -> after release with scan_en=1, ch_enable=4'b1111: first meas_sel=0.

Source files
------------

// File: rtl/fq_measure_scheduler.sv
`timescale 1ns / 1ps
// fq_measure_scheduler
// Time-shares one frequency-count engine across N_CH channels. Channels are
// visited round-robin over the ch_enable mask. Each visit selects the channel,
// lets the mux settle, opens a GATE_CYCLES gate, then waits for the engine's
// count. The latest count and the valid/timeout flags are kept per channel
// for readback.
//
// Ports
//   Clock, nReset       reference clock (posedge), async active-low reset
//   scan_en, ch_enable  run control and per-channel include mask
//   meas_sel            channel mux select to the engine
//   meas_start          1-cycle pulse on the last settle cycle (engine clears)
//   meas_gate           high for the GATE_CYCLES gate window
//   meas_done           1-cycle pulse from the engine, meas_count valid
//   meas_count          engine count for the last gate
//   rd_sel, rd_data     combinational result readback (0 when out of range)
//   rd_valid            per channel: result holds a completed count
//   rd_timeout          per channel: last attempt timed out
//   busy                high whenever not idle
//   scan_done           1-cycle pulse when the highest enabled channel finishes
module fq_measure_scheduler #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned GATE_CYCLES    = 1000000,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic                      scan_en,
  input  logic [N_CH-1:0]           ch_enable,
  output logic [$clog2(N_CH)-1:0]   meas_sel,
  output logic                      meas_start,
  output logic                      meas_gate,
  input  logic                      meas_done,
  input  logic [31:0]               meas_count,
  input  logic [$clog2(N_CH)-1:0]   rd_sel,
  output logic [31:0]               rd_data,
  output logic [N_CH-1:0]           rd_valid,
  output logic [N_CH-1:0]           rd_timeout,
  output logic                      busy,
  output logic                      scan_done
);

  localparam int unsigned SelW = $clog2(N_CH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSelect = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StGate   = 3'd3;
  localparam logic [2:0] StWait   = 3'd4;
  localparam logic [2:0] StNext   = 3'd5;

  localparam logic [31:0] SettleLast  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GateLast    = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic [N_CH-1:0] valid_q, timeout_q;
  logic [31:0]     result_q [N_CH];

  logic [SelW-1:0] next_ch, cand, hi_ch;
  logic            hi_found;
  logic            go;
  logic            store_done, store_timeout;

  assign go = scan_en & (|ch_enable);

  // First enabled channel after the pointer, wrapping. Iterating from the
  // farthest offset down lets the nearest hit win. An empty mask keeps ptr.
  always_comb begin
    next_ch = ptr_q;
    cand    = '0;
    for (int k = int'(N_CH); k >= 1; k--) begin
      cand = SelW'((int'(ptr_q) + k) % int'(N_CH));
      if (ch_enable[cand]) next_ch = cand;
    end
  end

  always_comb begin
    hi_ch    = '0;
    hi_found = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (ch_enable[i]) begin
        hi_ch    = SelW'(i);
        hi_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 32'd1;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    store_done    = 1'b0;
    store_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (go) state_d = StSelect;
      end
      StSelect: begin
        sel_d   = next_ch;
        ptr_d   = next_ch;
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StGate;
        end
      end
      StGate: begin
        if (cnt_q == GateLast) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A done arriving on the timeout cycle still counts as a result.
        if (meas_done) begin
          store_done = 1'b1;
          cnt_d      = '0;
          state_d    = StNext;
        end else if (cnt_q == TimeoutLast) begin
          store_timeout = 1'b1;
          cnt_d         = '0;
          state_d       = StNext;
        end
      end
      StNext: begin
        cnt_d   = '0;
        state_d = go ? StSelect : StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= SelW'(N_CH - 1);
      valid_q   <= '0;
      timeout_q <= '0;
      for (int i = 0; i < int'(N_CH); i++) result_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      if (store_done) begin
        result_q[sel_q]  <= meas_count;
        valid_q[sel_q]   <= 1'b1;
        timeout_q[sel_q] <= 1'b0;
      end
      if (store_timeout) timeout_q[sel_q] <= 1'b1;
    end
  end

  // Gate and start decode straight from state so an async reset drops them at once.
  assign meas_start = (state_q == StSettle) && (cnt_q == SettleLast);
  assign meas_gate  = (state_q == StGate);
  assign meas_sel   = sel_q;
  assign busy       = (state_q != StIdle);
  assign scan_done  = (state_q == StNext) && hi_found && (hi_ch == sel_q);
  assign rd_valid   = valid_q;
  assign rd_timeout = timeout_q;

  always_comb begin
    rd_data = '0;
    if (int'(rd_sel) < int'(N_CH)) rd_data = result_q[rd_sel];
  end

endmodule

// File: tb/tb_fq_measure_scheduler.sv
`timescale 1ns / 1ps
module tb_fq_measure_scheduler;
  localparam int N  = 4;
  localparam int G  = 100;
  localparam int S  = 4;
  localparam int TO = 50;

  logic        Clock, nReset, scan_en;
  logic [3:0]  ch_enable;
  logic [1:0]  meas_sel, rd_sel;
  logic        meas_start, meas_gate, meas_done, busy, scan_done;
  logic [31:0] meas_count, rd_data;
  logic [3:0]  rd_valid, rd_timeout;

  fq_measure_scheduler #(
    .N_CH(N), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock(Clock), .nReset(nReset), .scan_en(scan_en), .ch_enable(ch_enable),
    .meas_sel(meas_sel), .meas_start(meas_start), .meas_gate(meas_gate),
    .meas_done(meas_done), .meas_count(meas_count), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_timeout(rd_timeout), .busy(busy), .scan_done(scan_done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks, failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Engine model: answers eng_delay cycles after the gate falls (0 = never).
  logic        eng_done, spur_done, spur_en, rnd_vals, gate_prev;
  logic [31:0] eng_count;
  logic [31:0] eng_val [4];
  int          eng_delay, wcnt;
  assign meas_done  = eng_done | spur_done;
  assign meas_count = eng_count;

  always @(posedge Clock) begin
    #1;
    eng_done  = 1'b0;
    spur_done = 1'b0;
    if (!nReset) begin
      wcnt      = 0;
      gate_prev = 1'b0;
    end else begin
      if (gate_prev && !meas_gate) wcnt = 1;
      else if (wcnt > 0) wcnt++;
      if (wcnt > 0 && eng_delay > 0 && wcnt == eng_delay) begin
        eng_done  = 1'b1;
        eng_count = rnd_vals ? $urandom : eng_val[meas_sel];
        wcnt      = 0;
      end
      if (wcnt > 200) wcnt = 0;
      gate_prev = meas_gate;
      if (spur_en && (meas_gate || meas_start) && $urandom_range(0, 2) == 0) begin
        spur_done = 1'b1;
        eng_count = 32'hdead_0000 | 32'($urandom_range(0, 255));
      end
    end
  end

  // Observation monitor for the directed expectations.
  int   cyc, gate_run, last_gate_len, sd_cnt, gate_fall_cyc, to1_rise_cyc;
  logic gprev, to1_prev, seen3;
  int   st_q[$];

  always @(negedge Clock) begin
    cyc++;
    if (!nReset) begin
      gate_run = 0;
      gprev    = 1'b0;
      to1_prev = 1'b0;
    end else begin
      if (meas_gate) gate_run++;
      else if (gprev) begin
        last_gate_len = gate_run;
        gate_run      = 0;
        gate_fall_cyc = cyc;
      end
      if (meas_start) begin
        st_q.push_back(int'(meas_sel));
        if (meas_sel == 2'd3) seen3 = 1'b1;
      end
      if (scan_done) sd_cnt++;
      if (rd_timeout[1] && !to1_prev) to1_rise_cyc = cyc;
      gprev    = meas_gate;
      to1_prev = rd_timeout[1];
    end
  end

  // Reference model: each visit is timed as an offset t from its select cycle.
  int          m_mode;  // 0 idle, 1 visiting a channel, 2 wrap-up cycle
  int          m_t, m_sel, m_ptr;
  logic [31:0] m_res [4];
  logic [3:0]  m_val, m_to;

  function automatic int nextch(input int p, input logic [3:0] en);
    int r = p;
    for (int k = N; k >= 1; k--) if (en[(p + k) % N]) r = (p + k) % N;
    return r;
  endfunction

  function automatic int highest(input logic [3:0] en);
    int h = -1;
    for (int i = 0; i < N; i++) if (en[i]) h = i;
    return h;
  endfunction

  always @(negedge Clock) begin
    if (!nReset) begin
      m_mode = 0; m_t = 0; m_sel = 0; m_ptr = N - 1; m_val = '0; m_to = '0;
      for (int i = 0; i < N; i++) m_res[i] = '0;
    end
    chk("busy", busy, m_mode != 0);
    chk("meas_start", meas_start, m_mode == 1 && m_t == S);
    chk("meas_gate", meas_gate, m_mode == 1 && m_t >= S + 1 && m_t <= S + G);
    chk("meas_sel", meas_sel, m_sel);
    chk("scan_done", scan_done, m_mode == 2 && highest(ch_enable) == m_sel);
    chk("rd_valid", rd_valid, m_val);
    chk("rd_timeout", rd_timeout, m_to);
    chk("rd_data", rd_data, m_res[rd_sel]);
    if (nReset) begin
      case (m_mode)
        0: if (scan_en && ch_enable != 0) begin m_mode = 1; m_t = 0; end
        1: begin
          if (m_t == 0) begin
            m_ptr = nextch(m_ptr, ch_enable);
            m_sel = m_ptr;
            m_t   = 1;
          end else if (m_t <= S + G) begin
            m_t++;
          end else if (meas_done) begin
            m_res[m_sel] = meas_count;
            m_val[m_sel] = 1'b1;
            m_to[m_sel]  = 1'b0;
            m_mode       = 2;
          end else if (m_t - (S + G + 1) == TO - 1) begin
            m_to[m_sel] = 1'b1;
            m_mode      = 2;
          end else begin
            m_t++;
          end
        end
        default: begin
          m_mode = (scan_en && ch_enable != 0) ? 1 : 0;
          m_t    = 0;
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
      rd_sel = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin tick(1); n++; end
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    int n, k;
    checks = 0; failures = 0;
    nReset = 1'b0; scan_en = 1'b0; ch_enable = '0; rd_sel = '0;
    spur_en = 1'b0; rnd_vals = 1'b0; eng_delay = 0; eng_count = '0;
    eng_done = 1'b0; spur_done = 1'b0;
    for (int i = 0; i < N; i++) eng_val[i] = '0;
    cyc = 0; gate_run = 0; last_gate_len = 0; sd_cnt = 0; seen3 = 1'b0;
    gate_fall_cyc = -1; to1_rise_cyc = -1;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gate", meas_gate, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_sel", meas_sel, 0);
    nReset = 1'b1;
    tick(2);

    // Alternate ch0/ch2 with done three cycles after the gate.
    eng_val[0] = 32'd1234; eng_val[2] = 32'd5678; eng_delay = 3;
    st_q.delete(); sd_cnt = 0;
    ch_enable = 4'b0101; scan_en = 1'b1;
    tick(450);
    chk("s1_nstarts", st_q.size() >= 4, 1);
    if (st_q.size() >= 4) begin
      chk("s1_sel0", st_q[0], 0);
      chk("s1_sel1", st_q[1], 2);
      chk("s1_sel2", st_q[2], 0);
      chk("s1_sel3", st_q[3], 2);
    end
    chk("s1_scan_done_cnt", sd_cnt, 2);
    chk("s1_gate_len", last_gate_len, 100);
    chk("s1_valid", rd_valid, 4'b0101);
    rd_sel = 2'd0; #1 chk("s1_res0", rd_data, 1234);
    rd_sel = 2'd2; #1 chk("s1_res2", rd_data, 5678);
    rd_sel = 2'd1; #1 chk("s1_res1", rd_data, 0);

    // ch1 only, engine silent.
    scan_en = 1'b0;
    wait_idle(300);
    ch_enable = 4'b0010; eng_delay = 0; to1_rise_cyc = -1; gate_fall_cyc = -1;
    scan_en = 1'b1;
    tick(170);
    chk("s2_timeout_delay", to1_rise_cyc - gate_fall_cyc, 50);
    chk("s2_timeout1", rd_timeout[1], 1);
    chk("s2_valid1", rd_valid[1], 0);
    chk("s2_busy", busy, 1);
    chk("s2_sel", meas_sel, 1);

    // Spurious done pulses during settle and gate.
    n = st_q.size();
    spur_en = 1'b1;
    tick(260);
    spur_en = 1'b0;
    chk("s3_progress", st_q.size() > n, 1);
    chk("s3_gate_len", last_gate_len, 100);
    chk("s3_valid1", rd_valid[1], 0);
    rd_sel = 2'd1; #1 chk("s3_res1", rd_data, 0);

    // Drop scan_en mid-gate of ch3.
    scan_en = 1'b0;
    wait_idle(300);
    ch_enable = 4'b1000; eng_val[3] = $urandom; eng_delay = 3;
    scan_en = 1'b1;
    k = 0;
    while (!meas_gate && k < 50) begin tick(1); k++; end
    chk("s4_gate_seen", meas_gate, 1);
    tick(50);
    scan_en = 1'b0;
    n = st_q.size();
    wait_idle(200);
    chk("s4_gate_len", last_gate_len, 100);
    chk("s4_valid3", rd_valid[3], 1);
    rd_sel = 2'd3; #1 chk("s4_res3", rd_data, eng_val[3]);
    tick(30);
    chk("s4_no_restart", st_q.size(), n);
    chk("s4_idle", busy, 0);

    // Mask shrinks to ch1 while ch2 is being measured.
    for (int i = 0; i < N; i++) eng_val[i] = $urandom;
    ch_enable = 4'b1111; scan_en = 1'b1;
    k = 0;
    while (!(meas_gate && meas_sel == 2'd2) && k < 600) begin tick(1); k++; end
    chk("s5_ch2_gate", meas_gate && meas_sel == 2'd2, 1);
    ch_enable = 4'b0010;
    n = st_q.size(); seen3 = 1'b0;
    k = 0;
    while (st_q.size() <= n && k < 200) begin tick(1); k++; end
    chk("s5_next_start", st_q.size() > n, 1);
    if (st_q.size() > n) chk("s5_next_sel", st_q[n], 1);
    rd_sel = 2'd2; #1 chk("s5_res2", rd_data, eng_val[2]);
    tick(250);
    chk("s5_no_ch3", seen3, 0);

    // Async reset in mid-gate.
    k = 0;
    while (!meas_gate && k < 200) begin tick(1); k++; end
    chk("s6_gate_seen", meas_gate, 1);
    tick(20);
    #2 nReset = 1'b0;
    #1;
    chk("s6_gate", meas_gate, 0);
    chk("s6_busy", busy, 0);
    chk("s6_valid", rd_valid, 0);
    chk("s6_start", meas_start, 0);
    tick(2);
    ch_enable = 4'b1111; scan_en = 1'b1; nReset = 1'b1;
    n = st_q.size();
    k = 0;
    while (st_q.size() <= n && k < 50) begin tick(1); k++; end
    chk("s6_restart", st_q.size() > n, 1);
    if (st_q.size() > n) chk("s6_first_sel", st_q[n], 0);

    // Random traffic against the model.
    rnd_vals = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      if ($urandom_range(0, 99) == 0) ch_enable = 4'($urandom);
      if ($urandom_range(0, 149) == 0) scan_en = ~scan_en;
      if ($urandom_range(0, 49) == 0) eng_delay = $urandom_range(0, 60);
      if (i == 2000) begin
        #2 nReset = 1'b0;
        tick(2);
        nReset = 1'b1;
      end
    end
    scan_en = 1'b0;
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
